// File: rtl/snake_pkg.sv
// Shared encodings for the snake head datapath and its control.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package snake_pkg;

  localparam int COORD_W = 5;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_UP    = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10
  } state_t;

  // Moves are additions: +1 or -1 in two's complement, zero holds the axis.
  localparam logic [COORD_W-1:0] DELTA_POS  = 5'b00001;
  localparam logic [COORD_W-1:0] DELTA_NEG  = 5'b11111;
  localparam logic [COORD_W-1:0] DELTA_ZERO = 5'b00000;

  // The direction that would turn the snake back onto itself.
  function automatic logic [1:0] reverse_of(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/five_bit_adder.sv
// Five-bit ripple-carry adder built from a chain of full-adder cells.
// Latency: combinational.
// Backpressure: none.
module five_bit_adder (
  input  logic [4:0] A,
  input  logic [4:0] B,
  input  logic       Ci,
  output logic [4:0] SUM,
  output logic       Co
);

  logic carry;

  // Ripple the carry through one full-adder cell per bit.
  always_comb begin
    SUM   = '0;
    carry = Ci;
    for (int i = 0; i < 5; i++) begin
      SUM[i] = A[i] ^ B[i] ^ carry;
      carry  = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
    end
    Co = carry;
  end

endmodule

// File: rtl/snake_head_stepper.sv
// Snake head tracker: latches turn requests and steps the head one cell per tick.
// Latency: a tick sampled on one edge shows up on head_x/head_y/dir/moved one edge later.
// Backpressure: none; ticks outside RUN are dropped. SNAKE_WALL_WRAP_EN selects wrap vs wall death.
module snake_head_stepper
  import snake_pkg::*;
#(
  parameter int GRID_W  = 32,
  parameter int GRID_H  = 24,
  parameter int START_X = 16,
  parameter int START_Y = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 tick,
  input  logic [1:0]           dir_req,
  input  logic                 dir_req_valid,
  output logic [COORD_W-1:0]   head_x,
  output logic [COORD_W-1:0]   head_y,
  output logic [1:0]           dir,
  output logic                 moved,
  output logic                 running,
  output logic                 dead
);

  localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W-1:0] X_INIT = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] Y_INIT = COORD_W'(START_Y);

  state_t             state;
  logic [1:0]         pending_dir;

  logic               req_ok;
  logic [1:0]         eff_dir;
  logic [COORD_W-1:0] step_x;
  logic [COORD_W-1:0] step_y;
  logic [COORD_W-1:0] sum_x;
  logic [COORD_W-1:0] sum_y;
  logic               carry_x_unused;
  logic               carry_y_unused;
  logic               edge_right;
  logic               edge_left;
  logic               edge_down;
  logic               edge_up;
  logic [COORD_W-1:0] next_x;
  logic [COORD_W-1:0] next_y;
  logic               blocked;

  // Legality is judged against the committed direction so that two quick
  // turns between ticks can never add up to a reversal.
  assign req_ok  = dir_req_valid && (dir_req != reverse_of(dir));
  assign eff_dir = req_ok ? dir_req : pending_dir;

  // Select the per-axis delta and flag moves that would leave the field.
  always_comb begin
    step_x = DELTA_ZERO;
    step_y = DELTA_ZERO;
    case (eff_dir)
      DIR_RIGHT: step_x = DELTA_POS;
      DIR_LEFT:  step_x = DELTA_NEG;
      DIR_DOWN:  step_y = DELTA_POS;
      default:   step_y = DELTA_NEG;
    endcase
    edge_right = (eff_dir == DIR_RIGHT) && (head_x == X_MAX);
    edge_left  = (eff_dir == DIR_LEFT)  && (head_x == '0);
    edge_down  = (eff_dir == DIR_DOWN)  && (head_y == Y_MAX);
    edge_up    = (eff_dir == DIR_UP)    && (head_y == '0);
  end

  five_bit_adder u_add_x (
    .A   (head_x),
    .B   (step_x),
    .Ci  (1'b0),
    .SUM (sum_x),
    .Co  (carry_x_unused)
  );

  five_bit_adder u_add_y (
    .A   (head_y),
    .B   (step_y),
    .Ci  (1'b0),
    .SUM (sum_y),
    .Co  (carry_y_unused)
  );

  // Resolve the next head position: wrap at the edges, or block the move.
  always_comb begin
    next_x  = sum_x;
    next_y  = sum_y;
    blocked = 1'b0;
`ifdef SNAKE_WALL_WRAP_EN
    // Grid sizes below 32 do not wrap naturally in 5 bits, so force it.
    if (edge_right)     next_x = '0;
    else if (edge_left) next_x = X_MAX;
    if (edge_down)      next_y = '0;
    else if (edge_up)   next_y = Y_MAX;
`else
    blocked = edge_right | edge_left | edge_down | edge_up;
`endif
  end

  // Game control and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      head_x      <= X_INIT;
      head_y      <= Y_INIT;
      dir         <= DIR_RIGHT;
      pending_dir <= DIR_RIGHT;
      moved       <= 1'b0;
      running     <= 1'b0;
      dead        <= 1'b0;
    end else begin
      moved <= 1'b0;
      case (state)
        ST_RUN: begin
          if (tick) begin
            if (blocked) begin
              state   <= ST_DEAD;
              running <= 1'b0;
              dead    <= 1'b1;
              if (req_ok) pending_dir <= dir_req;
            end else begin
              head_x      <= next_x;
              head_y      <= next_y;
              dir         <= eff_dir;
              pending_dir <= eff_dir;
              moved       <= 1'b1;
            end
          end else if (req_ok) begin
            pending_dir <= dir_req;
          end
        end
        default: begin
          // IDLE and DEAD behave alike: wait for start, keep turn requests.
          if (start) begin
            state       <= ST_RUN;
            head_x      <= X_INIT;
            head_y      <= Y_INIT;
            dir         <= DIR_RIGHT;
            pending_dir <= DIR_RIGHT;
            running     <= 1'b1;
            dead        <= 1'b0;
          end else if (req_ok) begin
            pending_dir <= dir_req;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_head_stepper.sv
// Directed bench for snake_head_stepper with hand-computed expected values.
// Latency: checks one edge after each driven cycle.
// Backpressure: n/a. Follows SNAKE_WALL_WRAP_EN to pick wrap or wall expectations.
module tb_snake_head_stepper;

  logic       clk;
  logic       rst;
  logic       start;
  logic       tick;
  logic [1:0] dir_req;
  logic       dir_req_valid;
  logic [4:0] head_x;
  logic [4:0] head_y;
  logic [1:0] dir;
  logic       moved;
  logic       running;
  logic       dead;

  int tests;
  int failed;

  snake_head_stepper dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .tick          (tick),
    .dir_req       (dir_req),
    .dir_req_valid (dir_req_valid),
    .head_x        (head_x),
    .head_y        (head_y),
    .dir           (dir),
    .moved         (moved),
    .running       (running),
    .dead          (dead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       tk;
    logic [1:0] req;
    logic       vld;
    logic [4:0] x;
    logic [4:0] y;
    logic [1:0] d;
    logic       mv;
    logic       run;
    logic       dd;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [4:0] x, input logic [4:0] y,
                            input logic [1:0] d, input logic mv, input logic run,
                            input logic dd);
    check({tag, " head_x"},  {27'd0, head_x}, {27'd0, x});
    check({tag, " head_y"},  {27'd0, head_y}, {27'd0, y});
    check({tag, " dir"},     {30'd0, dir},    {30'd0, d});
    check({tag, " moved"},   {31'd0, moved},  {31'd0, mv});
    check({tag, " running"}, {31'd0, running}, {31'd0, run});
    check({tag, " dead"},    {31'd0, dead},   {31'd0, dd});
  endtask

  // Drive one cycle of inputs at the falling edge, sample just after the rising edge.
  task automatic step(input logic st, input logic tk, input logic [1:0] req, input logic vld);
    @(negedge clk);
    start         = st;
    tick          = tk;
    dir_req       = req;
    dir_req_valid = vld;
    @(posedge clk);
    #1;
    start         = 1'b0;
    tick          = 1'b0;
    dir_req_valid = 1'b0;
  endtask

  initial begin
    tests = 0;
    failed = 0;
    rst = 1'b0;
    start = 1'b0;
    tick = 1'b0;
    dir_req = 2'b00;
    dir_req_valid = 1'b0;

    //            st tk req   vld  x      y      d     mv run dd
    vecs[0]  = '{0, 0, 2'b00, 0, 5'd16, 5'd12, 2'b00, 0, 0, 0}; // idle
    vecs[1]  = '{0, 1, 2'b00, 0, 5'd16, 5'd12, 2'b00, 0, 0, 0}; // tick ignored in IDLE
    vecs[2]  = '{1, 0, 2'b00, 0, 5'd16, 5'd12, 2'b00, 0, 1, 0}; // start
    vecs[3]  = '{0, 1, 2'b00, 0, 5'd17, 5'd12, 2'b00, 1, 1, 0};
    vecs[4]  = '{0, 1, 2'b00, 0, 5'd18, 5'd12, 2'b00, 1, 1, 0};
    vecs[5]  = '{0, 1, 2'b00, 0, 5'd19, 5'd12, 2'b00, 1, 1, 0};
    vecs[6]  = '{0, 0, 2'b00, 0, 5'd19, 5'd12, 2'b00, 0, 1, 0}; // moved drops
    vecs[7]  = '{0, 1, 2'b10, 1, 5'd20, 5'd12, 2'b00, 1, 1, 0}; // reversal dropped
    vecs[8]  = '{0, 0, 2'b01, 1, 5'd20, 5'd12, 2'b00, 0, 1, 0}; // pending down
    vecs[9]  = '{0, 0, 2'b10, 1, 5'd20, 5'd12, 2'b00, 0, 1, 0}; // left vs committed right
    vecs[10] = '{0, 1, 2'b00, 0, 5'd20, 5'd13, 2'b01, 1, 1, 0}; // moves down
    vecs[11] = '{1, 1, 2'b00, 0, 5'd20, 5'd14, 2'b01, 1, 1, 0}; // start ignored in RUN
    vecs[12] = '{0, 1, 2'b00, 1, 5'd21, 5'd14, 2'b00, 1, 1, 0}; // same-cycle request wins
    vecs[13] = '{0, 1, 2'b11, 1, 5'd21, 5'd13, 2'b11, 1, 1, 0}; // turn up
    vecs[14] = '{0, 1, 2'b01, 1, 5'd21, 5'd12, 2'b11, 1, 1, 0}; // down is reversal of up

    // Asynchronous reset asserted before any clock edge.
    #1 rst = 1'b1;
    #2;
    expect_all("reset", 5'd16, 5'd12, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].st, vecs[i].tk, vecs[i].req, vecs[i].vld);
      expect_all($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].d,
                 vecs[i].mv, vecs[i].run, vecs[i].dd);
    end

    // Run right to the last column.
    step(1'b0, 1'b1, 2'b00, 1'b1);
    expect_all("turn_right", 5'd22, 5'd12, 2'b00, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 2'b00, 1'b0);
    expect_all("at_x31", 5'd31, 5'd12, 2'b00, 1'b1, 1'b1, 1'b0);

`ifdef SNAKE_WALL_WRAP_EN
    step(1'b0, 1'b1, 2'b00, 1'b0);
    expect_all("wrap_right", 5'd0, 5'd12, 2'b00, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 2'b00, 1'b0);
    expect_all("start_in_run", 5'd0, 5'd12, 2'b00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'b11, 1'b1);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 2'b00, 1'b0);
    expect_all("at_y0", 5'd0, 5'd0, 2'b11, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'b00, 1'b0);
    expect_all("wrap_up", 5'd0, 5'd23, 2'b11, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'b10, 1'b1);
    expect_all("wrap_left", 5'd31, 5'd23, 2'b10, 1'b1, 1'b1, 1'b0);
`else
    step(1'b0, 1'b1, 2'b00, 1'b0);
    expect_all("wall_right", 5'd31, 5'd12, 2'b00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 2'b00, 1'b0);
    expect_all("tick_in_dead", 5'd31, 5'd12, 2'b00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 2'b01, 1'b1);
    step(1'b1, 1'b0, 2'b01, 1'b1);
    expect_all("restart", 5'd16, 5'd12, 2'b00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'b00, 1'b0);
    expect_all("restart_move", 5'd17, 5'd12, 2'b00, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'b11, 1'b1);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 2'b00, 1'b0);
    expect_all("at_y0", 5'd17, 5'd0, 2'b11, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'b00, 1'b0);
    expect_all("wall_up", 5'd17, 5'd0, 2'b11, 1'b0, 1'b0, 1'b1);
`endif

    // Reset mid-game, checked before the next rising edge.
    #2 rst = 1'b1;
    #1;
    expect_all("async_rst", 5'd16, 5'd12, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, 2'b00, 1'b0);
    expect_all("post_rst_idle", 5'd16, 5'd12, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
